// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, instruction types and the
// long-op sequencer state encoding.
package mips_pkg;

    localparam logic [5:0] ADD    = 6'b000000;
    localparam logic [5:0] SUB    = 6'b000001;
    localparam logic [5:0] AND_OP = 6'b000010;
    localparam logic [5:0] OR_OP  = 6'b000011;
    localparam logic [5:0] SLT    = 6'b000100;
    localparam logic [5:0] MUL    = 6'b000101;
    localparam logic [5:0] DIV    = 6'b000110;
    localparam logic [5:0] POW    = 6'b010000;
    localparam logic [5:0] HLT    = 6'b111111;
    localparam logic [5:0] LW     = 6'b001000;
    localparam logic [5:0] SW     = 6'b001001;
    localparam logic [5:0] ADDI   = 6'b001010;
    localparam logic [5:0] SUBI   = 6'b001011;
    localparam logic [5:0] SLTI   = 6'b001100;
    localparam logic [5:0] BNEQZ  = 6'b001101;
    localparam logic [5:0] BEQZ   = 6'b001110;

    localparam logic [2:0] RR_ALU = 3'b000;
    localparam logic [2:0] RM_ALU = 3'b001;
    localparam logic [2:0] LOAD   = 3'b010;
    localparam logic [2:0] STORE  = 3'b011;
    localparam logic [2:0] BRANCH = 3'b100;
    localparam logic [2:0] HALT_T = 3'b101;
    localparam logic [2:0] NOP_T  = 3'b110;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StMulRun = 3'd1,
        StDivRun = 3'd2,
        StPowRun = 3'd3,
        StDone   = 3'd4
    } seq_state_e;

    function automatic logic is_long_op(input logic [5:0] op);
        return (op == MUL) || (op == DIV) || (op == POW);
    endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// One-bit-per-cycle datapath: unsigned shift-add multiply or restoring divide.
// next_val is the value the result will take after the current step.
module iter_muldiv_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] load_a,
    input  logic [XLEN-1:0] load_b,
    output logic [XLEN-1:0] next_val,
    output logic            step_done
);

    localparam int unsigned CNT_W = 6;

    logic            mode_q;
    logic [XLEN:0]   acc_q;    // product (mul) or partial remainder (div)
    logic [XLEN-1:0] opnd_q;   // multiplicand (mul) or divisor (div)
    logic [XLEN-1:0] shreg_q;  // multiplier (mul) or dividend/quotient (div)
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN-1:0] mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] quo_next;

    always_comb begin
        mul_sum   = acc_q[XLEN-1:0] + (shreg_q[0] ? opnd_q : '0);
        rem_sh    = {acc_q[XLEN-1:0], shreg_q[XLEN-1]};
        diff      = rem_sh - {1'b0, opnd_q};
        fits      = ~diff[XLEN];
        quo_next  = {shreg_q[XLEN-2:0], fits};
        next_val  = mode_q ? quo_next : mul_sum;
        step_done = step && (cnt_q == CNT_W'(XLEN - 1));
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            mode_q  <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            mode_q  <= div_mode;
            acc_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= div_mode ? load_b : load_a;
            shreg_q <= div_mode ? load_a : load_b;
        end else if (step) begin
            cnt_q <= step_done ? '0 : cnt_q + 1'b1;
            if (mode_q) begin
                acc_q   <= fits ? diff : rem_sh;
                shreg_q <= quo_next;
            end else begin
                acc_q   <= {1'b0, mul_sum};
                opnd_q  <= opnd_q << 1;
                shreg_q <= shreg_q >> 1;
            end
        end
    end

endmodule

// File: rtl/long_op_sequencer.sv
// Multi-cycle controller for MUL/DIV/POW in EX; stalls the pipeline while the
// shared iterative core runs and pulses done with the result.
module long_op_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned POW_MAX_EXP = 8
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      opcode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam int unsigned EXP_W = $clog2(POW_MAX_EXP + 1);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            dbz_q, dbz_d;
    logic            busy_q;
    logic [XLEN-1:0] base_q, base_d;
    logic [EXP_W-1:0] exp_q, exp_d;

    logic            accept;
    logic [EXP_W-1:0] eff_exp;
    logic            core_load, core_step, core_div;
    logic [XLEN-1:0] core_a, core_b, core_next;
    logic            core_step_done;

    iter_muldiv_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk1     (clk1),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .div_mode (core_div),
        .load_a   (core_a),
        .load_b   (core_b),
        .next_val (core_next),
        .step_done(core_step_done)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        base_d    = base_q;
        exp_d     = exp_q;
        core_load = 1'b0;
        core_step = 1'b0;
        core_div  = 1'b0;
        core_a    = op_a;
        core_b    = op_b;
        stall     = 1'b0;
        done      = 1'b0;
        accept    = start && is_long_op(opcode) && !flush;
        eff_exp   = (op_b > XLEN'(POW_MAX_EXP)) ? EXP_W'(POW_MAX_EXP) : op_b[EXP_W-1:0];

        case (state_q)
            StIdle: begin
                if (accept) begin
                    stall = 1'b1;
                    dbz_d = 1'b0;
                    case (opcode)
                        MUL: begin
                            core_load = 1'b1;
                            state_d   = StMulRun;
                        end
                        DIV: begin
                            if (op_b == '0) begin
                                result_d = '1;
                                dbz_d    = 1'b1;
                                state_d  = StDone;
                            end else begin
                                core_load = 1'b1;
                                core_div  = 1'b1;
                                state_d   = StDivRun;
                            end
                        end
                        default: begin
                            if (eff_exp == '0) begin
                                result_d = XLEN'(1);
                                state_d  = StDone;
                            end else begin
                                // acc starts at 1 and is the multiplier of each pass
                                core_load = 1'b1;
                                core_b    = XLEN'(1);
                                base_d    = op_a;
                                exp_d     = eff_exp;
                                state_d   = StPowRun;
                            end
                        end
                    endcase
                end
            end
            StMulRun, StDivRun: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    core_step = 1'b1;
                    if (core_step_done) begin
                        result_d = core_next;
                        state_d  = StDone;
                    end
                end
            end
            StPowRun: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    core_step = 1'b1;
                    if (core_step_done) begin
                        if (exp_q == EXP_W'(1)) begin
                            result_d = core_next;
                            state_d  = StDone;
                        end else begin
                            // Restart on the same edge so passes run back to back
                            core_load = 1'b1;
                            core_a    = base_q;
                            core_b    = core_next;
                            exp_d     = exp_q - 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            base_q   <= '0;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            busy_q   <= (state_d == StMulRun) || (state_d == StDivRun) || (state_d == StPowRun);
            base_q   <= base_d;
            exp_q    <= exp_d;
        end
    end

    assign busy        = busy_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_long_op_sequencer.sv
// Self-checking bench for long_op_sequencer: directed scenarios plus random
// MUL/DIV/POW against an arithmetic reference model.
module tb_long_op_sequencer;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_MUL = 6'b000101;
    localparam logic [5:0] OP_DIV = 6'b000110;
    localparam logic [5:0] OP_POW = 6'b010000;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done, div_by_zero;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_result = '0;

    long_op_sequencer #(
        .XLEN       (32),
        .POW_MAX_EXP(8)
    ) dut (
        .clk1       (clk1),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint unsigned r;
        int unsigned e;
        if (op == OP_MUL) return 32'(longint'(a) * longint'(b));
        if (op == OP_DIV) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        e = (b > 8) ? 8 : b;
        r = 1;
        for (int i = 0; i < int'(e); i++) r = (r * a) & 64'hFFFF_FFFF;
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [5:0] op, input logic [31:0] b);
        if (op == OP_MUL) return 33;
        if (op == OP_DIV) return (b == 0) ? 1 : 33;
        return 32 * ((b > 8) ? 8 : int'(b)) + 1;
    endfunction

    // Drives one accepted op and observes latency (accept cycle = 0), result and handshakes.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic dz,
                         output int stall_cyc, output logic stall_done,
                         output logic extra_done, output logic busy_ok);
        start = 1'b1; opcode = op; op_a = a; op_b = b;
        #1;
        stall_cyc = stall ? 1 : 0;
        busy_ok = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!done && lat < 400) begin
            if (stall) stall_cyc++;
            if (!busy) busy_ok = 1'b0;
            @(posedge clk1); #1;
            lat++;
        end
        if (!done) lat = -1;
        res = result; dz = div_by_zero; stall_done = stall;
        if (busy) busy_ok = 1'b0;
        @(posedge clk1); #1;
        extra_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        rst = 1'b0;
        model_result = '0;
    endtask

    task automatic test_op(input string name, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        int lat, sc, exp_lat;
        logic [31:0] res, exp_res;
        logic dz, sd, xd, bok;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op, b);
        do_op(op, a, b, lat, res, dz, sc, sd, xd, bok);
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
        checks++; if (res !== exp_res) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, res, exp_res); end
        checks++; if (dz !== (op == OP_DIV && b == 0)) begin errors++; $display("FAIL %s_dbz got=%b", name, dz); end
        checks++; if (sc != exp_lat) begin errors++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, sc, exp_lat); end
        checks++; if (sd !== 1'b0 || xd !== 1'b0) begin errors++; $display("FAIL %s_done_pulse stall_at_done=%b done_after=%b exp=0,0", name, sd, xd); end
        checks++; if (!bok) begin errors++; $display("FAIL %s_busy got=bad exp=high-in-run-only", name); end
        model_result = exp_res;
    endtask

    task automatic test_non_long();
        int n_done = 0, n_busy = 0;
        start = 1'b1; opcode = OP_ADD; op_a = 32'd5; op_b = 32'd6;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nonlong_stall got=%b exp=0", stall); end
        repeat (5) begin
            @(posedge clk1); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        start = 1'b0;
        checks++; if (n_done + n_busy != 0) begin errors++; $display("FAIL nonlong_activity done=%0d busy=%0d exp=0", n_done, n_busy); end
        checks++; if (result !== model_result) begin errors++; $display("FAIL nonlong_result got=%h exp=%h", result, model_result); end
    endtask

    task automatic test_flush();
        int n_done = 0;
        // Flush in IDLE beats start
        start = 1'b1; flush = 1'b1; opcode = OP_MUL; op_a = 32'd3; op_b = 32'd4;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
        @(posedge clk1); #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
        // Flush mid DIV at cycle 10
        start = 1'b1; opcode = OP_DIV; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (9) @(posedge clk1);
        #1;
        flush = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_run_busy got=%b exp=1", busy); end
        @(posedge clk1); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_abort busy=%b stall=%b exp=0,0", busy, stall); end
        repeat (40) begin
            @(posedge clk1); #1;
            if (done) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", n_done); end
        checks++; if (result !== model_result) begin errors++; $display("FAIL flush_result got=%h exp=%h", result, model_result); end
    endtask

    task automatic test_start_held();
        int n_done = 0, k = 0;
        start = 1'b1; opcode = OP_MUL; op_a = 32'd11; op_b = 32'd13;
        while (!done && k < 60) begin
            @(posedge clk1); #1;
            k++;
        end
        if (done) n_done++;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (40) begin
            @(posedge clk1); #1;
            if (done) n_done++;
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL held_done_count got=%0d exp=1", n_done); end
        checks++; if (result !== 32'd143) begin errors++; $display("FAIL held_result got=%h exp=%h", result, 32'd143); end
        model_result = 32'd143;
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1; opcode = OP_POW; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (49) @(posedge clk1);
        #1;
        rst = 1'b1;
        @(posedge clk1); #1;
        rst = 1'b0;
        checks++; if ({stall, busy, done, div_by_zero} !== 4'b0) begin errors++; $display("FAIL midrst_ctrl got=%b exp=0000", {stall, busy, done, div_by_zero}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h exp=0", result); end
        model_result = '0;
        test_op("after_rst_mul", OP_MUL, 32'd2, 32'd3);
    endtask

    task automatic test_random();
        logic [5:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(2))
                0: op = OP_MUL;
                1: op = OP_DIV;
                default: op = OP_POW;
            endcase
            a = $urandom;
            b = $urandom;
            if (op == OP_DIV && $urandom_range(3) == 0) b = 0;
            else if (op == OP_DIV && $urandom_range(1) == 0) b = $urandom_range(200);
            if (op == OP_POW) begin
                a = $urandom_range(20);
                if ($urandom_range(1) == 0) b = $urandom_range(10);
            end
            test_op("random", op, a, b);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk1); #1;
        test_op("mul_7x6", OP_MUL, 32'd7, 32'd6);
        test_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_op("div_100_7", OP_DIV, 32'd100, 32'd7);
        test_op("div_by_0", OP_DIV, 32'd5, 32'd0);
        test_op("div_after_dbz", OP_DIV, 32'hFFFF_FFFF, 32'd1);
        test_op("pow_3_4", OP_POW, 32'd3, 32'd4);
        test_op("pow_2_20", OP_POW, 32'd2, 32'd20);
        test_op("pow_9_0", OP_POW, 32'd9, 32'd0);
        test_op("pow_3_8", OP_POW, 32'd3, 32'd8);
        test_op("pow_3_9", OP_POW, 32'd3, 32'd9);
        test_non_long();
        test_flush();
        test_start_held();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/long_op_sequencer.md
Name: long_op_sequencer

Overview:
Multi-cycle execution controller for the long-latency RR_ALU opcodes MUL, DIV and POW in the 5-stage MIPS pipeline. It replaces single-cycle combinational multiply, divide and unrolled-power logic with an iterative shift-add/restoring-divide engine. While an operation runs, it holds the EX stage via a stall output. Sits beside the EX stage: EX presents opcode and operands, the sequencer returns a result plus a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width
POW_MAX_EXP, 8, exponent saturation limit for POW (matches the pipeline's architectural POW definition)

Ports:
clk1  in  1  pipeline clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
start  in  1  EX stage holds a candidate instruction (level; sampled only in IDLE)
opcode  in  6  ID_EX_IR[31:26]
op_a  in  XLEN  ID_EX_A (multiplicand / dividend / base)
op_b  in  XLEN  ID_EX_B (multiplier / divisor / exponent)
flush  in  1  taken-branch squash; aborts the current operation
stall  out  1  freeze IF/ID/EX pipeline registers
busy  out  1  FSM not in IDLE or DONE
done  out  1  one-cycle pulse, result valid
result  out  XLEN  low XLEN bits of the final result; held until the next accepted start
div_by_zero  out  1  set with done for DIV with op_b==0; cleared on the next accepted start

Behaviour:
- Reset (synchronous, rst high at posedge): state=IDLE, stall=0, busy=0, done=0, result=0, div_by_zero=0, all iteration registers=0. Applies mid-operation; no done is issued for an aborted operation.
- Long ops: MUL=6'b000101, DIV=6'b000110, POW=6'b010000. start with any other opcode is ignored (no stall, no done).
- States: IDLE, MUL_RUN, DIV_RUN, POW_RUN, DONE.
- IDLE:
  - start & long op & !flush -> accept: latch operands, clear div_by_zero, go to the matching RUN state.
  - DIV with op_b==0 -> DONE directly: result=32'hFFFF_FFFF, div_by_zero=1.
  - POW with exponent 0 -> DONE directly: result=1.
- MUL_RUN: unsigned shift-add, one multiplier bit per cycle, 32 cycles, then DONE. Result is the product mod 2^32.
- DIV_RUN: unsigned restoring division, one quotient bit per cycle, 32 cycles, then DONE. result=quotient; remainder discarded.
- POW_RUN:
  - Effective exponent e = min(op_b, POW_MAX_EXP), op_b unsigned.
  - acc starts at 1. Each step is a full 32-cycle shift-add of acc*op_a (mod 2^32). e steps, then DONE.
  - Total cycles from accept to DONE entry = 32*e.
- DONE: done=1 for exactly this cycle, stall=0, then IDLE. start in DONE is ignored: it is the completed instruction still in EX.
- Latency (accepting edge to done high): MUL/DIV 33 cycles; DIV-by-0 1; POW 32*e+1; POW e=0 1.
- stall (combinational):
  - High in MUL_RUN, DIV_RUN, POW_RUN.
  - High in IDLE when start & long op & !flush (holds EX in the accept cycle).
  - Low in DONE, and low in IDLE otherwise.
- busy (registered from state): high in RUN states only.
- flush:
  - In any RUN state: return to IDLE next edge, no done, result and div_by_zero unchanged.
  - In IDLE: blocks acceptance (flush wins over start).
  - In DONE: no effect.
- start while busy: ignored; operands are latched only at acceptance, so op_a/op_b changes mid-operation have no effect.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants ADD..POW, HLT, LW, SW, ADDI, SUBI, SLTI, BNEQZ, BEQZ
  - instruction-type constants RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT_T, NOP_T
  - sequencer state encoding
  - is_long_op function
- One sub-module: iter_muldiv_core. A one-bit-per-cycle shared datapath (shift-add step / restoring-subtract step, 6-bit iteration counter, step_done flag), driven by the sequencer FSM. POW reuses it in multiply mode.

Test Plan:
- MUL op_a=7, op_b=6, start for 1 accept: stall high 33 cycles incl. accept, done at cycle 33, result=42. Also op_a=op_b=32'hFFFF_FFFF -> result=1.
- DIV 100/7 -> done at cycle 33, result=14, div_by_zero=0. DIV 5/0 -> done 1 cycle after accept, result=32'hFFFF_FFFF, div_by_zero=1.
- POW 3,4 -> done at cycle 129, result=81. POW 2,20 -> e saturates to 8, done at 257, result=256. POW 9,0 -> done at cycle 1, result=1.
- Non-long opcode ADD with start=1 -> stall=0, busy=0, no done, result unchanged.
- DIV 100/7 accepted, flush at cycle 10 -> IDLE next cycle, no done, result keeps prior value. start held high through DONE -> only one done pulse.
- rst asserted at cycle 50 of POW 3,4 -> next edge all outputs 0, state IDLE. New MUL 2*3 afterwards -> result=6 at cycle 33.
